output_uart_streamer: RTL and testbench
=======================================

Name: output_uart_streamer

Overview:
- Downstream consumer of the processor's output path: captures each 16-bit result word when the processor executes an output instruction (REG->Output or RAM->Output).
- Buffers captured words in a small FIFO and serialises them on a UART TX line (8N1, LSB first) so puzzle answers reach a host terminal.
- Decouples processor execution rate from line rate. Overflow is flagged, never stalls the processor.

Parameters:
- DATA_WIDTH, 16, width of captured word; must be a multiple of 8.
- FIFO_DEPTH, 8, word entries; power of 2, >= 2.
- CLKS_PER_BIT, 434, clk cycles per UART bit; >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  DATA_WIDTH  processor data bus value to capture.
- data_valid  input  1  one-cycle strobe; data_in is pushed on this rising edge.
- uart_tx  output  1  serial line, idle high.
- busy  output  1  high while a frame/word is being transmitted.
- fifo_empty  output  1  FIFO holds no words.
- fifo_full  output  1  FIFO holds FIFO_DEPTH words.
- overflow  output  1  sticky: a push was dropped.

Behaviour:
- Reset values: uart_tx=1, busy=0, fifo_empty=1, fifo_full=0, overflow=0. FIFO pointers/count=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts immediately (async): line returns high and FIFO contents are discarded.
- FIFO: circular buffer with write/read pointers and count of width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Push: data_valid=1 and (not full or pop in same cycle).
- Pop: only from IDLE when not empty.
- Simultaneous push+pop when full: both occur, count unchanged, no overflow.
- Push when full without pop: word dropped, overflow<=1 until reset.
- fifo_empty/fifo_full are registered views of count.
- FSM states:
  - IDLE: uart_tx=1, busy=0. If !fifo_empty, pop word into shift register, load char index 0, go START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: uart_tx=current char bit[idx], LSB first, each bit CLKS_PER_BIT cycles. After bit 7 go STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. If more chars remain in the word, advance char index and go START directly (no idle gap). Else go IDLE.
- busy=1 in START/DATA/STOP.
- Latency: word pushed at edge N with FSM idle and FIFO empty is popped at edge N+1. uart_tx goes low from edge N+1 (registered output).
- Back-to-back words: exactly one IDLE cycle (line high) between the last stop bit of one word and the next start bit.
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads on every bit boundary.

Optional Feature:
- Macro: OUTPUT_UART_ASCII_HEX_EN.
- Defined: each word is sent as DATA_WIDTH/4 uppercase ASCII hex characters, most significant nibble first, followed by 0x0D, 0x0A. Nibble 0-9 maps to 0x30+n; nibble A-F maps to 0x41+(n-10). At 16 bits this is 6 chars per word.
- Undefined: each word is sent as DATA_WIDTH/8 raw bytes, most significant byte first, with no terminator. At 16 bits this is 2 chars per word.

Test Plan:
- CLKS_PER_BIT=4, HEX_EN defined: push 0x1A2F at edge N -> uart_tx low at N+1. Decoded bytes 0x31,0x41,0x32,0x46,0x0D,0x0A. busy high 240 cycles. fifo_empty=1 from N+2.
- HEX_EN undefined, CLKS_PER_BIT=4: push 0x1A2F -> bytes 0x1A then 0x2F, busy 80 cycles, then uart_tx=1 idle.
- HEX_EN defined: push 0x0000 then 0xFFFF on consecutive cycles -> "0000\r\n" then one idle-high cycle, then "FFFF\r\n".
- Depth 8: push 10 words 0x0001..0x000A on 10 consecutive cycles from idle -> word 1 popped on the cycle after its push, words 2-9 buffered, fifo_full=1. Word 10 dropped, overflow=1. Line carries exactly words 1-9 in order.
- With FIFO full during transmission, assert data_valid (0x00BB) on the exact pop cycle -> accepted, count stays 8, overflow stays 0, 0x00BB transmitted last.
- Assert reset=0 mid-way through the DATA bits of a char -> same cycle: uart_tx=1, busy=0, fifo_empty=1, overflow=0. After release, push 0x0042 transmits correctly from START.

Source files
------------

// File: rtl/output_uart_streamer.sv
// rtl/output_uart_streamer.sv - captures output words into a FIFO and serialises them on an 8N1 UART line
//
// Purpose:
//   Each data_valid strobe pushes data_in into a small circular FIFO. A
//   transmit FSM pops one word at a time from IDLE and sends it as a sequence
//   of 8N1 characters, LSB first, on uart_tx. A push that finds the FIFO full
//   (and no pop in the same cycle) is dropped and sets a sticky overflow flag.
//   The processor is never stalled.
//
// Optional feature (macro OUTPUT_UART_ASCII_HEX_EN):
//   defined   - each word goes out as DATA_WIDTH/4 uppercase ASCII hex digits,
//               most significant nibble first, followed by CR LF.
//   undefined - each word goes out as DATA_WIDTH/8 raw bytes, MSB first.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   data_in    - word to capture
//   data_valid - one-cycle push strobe
//   uart_tx    - serial line, idle high (registered)
//   busy       - high while a word is being transmitted (registered)
//   fifo_empty - registered view of count == 0
//   fifo_full  - registered view of count == FIFO_DEPTH
//   overflow   - sticky: a push was dropped

module output_uart_streamer #(
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  uart_tx,
    output logic                  busy,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
`ifdef OUTPUT_UART_ASCII_HEX_EN
    localparam int NIBBLES   = DATA_WIDTH / 4;
    localparam int NUM_CHARS = NIBBLES + 2;
`else
    localparam int NUM_CHARS = DATA_WIDTH / 8;
`endif
    localparam int IDX_W = $clog2(NUM_CHARS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  count_full;
    logic                  push;
    logic                  pop;

    // Transmitter state
    state_t                state;
    state_t                state_next;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BAUD_W-1:0]     baud_next;
    logic                  baud_done;
    logic [2:0]            bit_idx;
    logic [2:0]            bit_next;
    logic [IDX_W-1:0]      char_idx;
    logic [IDX_W-1:0]      char_next;
    logic [DATA_WIDTH-1:0] word_reg;
    logic [DATA_WIDTH-1:0] word_next;
    logic [7:0]            cur_char;
    logic [7:0]            cur_char_next;
    logic                  last_char;
    logic                  tx_next;
    logic                  busy_next;

    // Character number idx of word w, in transmission order.
    function automatic logic [7:0] char_of(input logic [DATA_WIDTH-1:0] w,
                                           input logic [IDX_W-1:0]      idx);
        logic [7:0] ch;
`ifdef OUTPUT_UART_ASCII_HEX_EN
        logic [3:0] nib;
        nib = 4'h0;
        ch  = 8'h0A;
        if (idx < IDX_W'(NIBBLES)) begin
            nib = 4'(w >> (DATA_WIDTH - 4 * (int'(idx) + 1)));
            // '0'..'9' start at 0x30; 'A' is 0x41 = 0x37 + 10
            ch  = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end else if (idx == IDX_W'(NIBBLES)) begin
            ch = 8'h0D;
        end
`else
        ch = 8'(w >> (DATA_WIDTH - 8 * (int'(idx) + 1)));
`endif
        return ch;
    endfunction

    assign count_full = (count == CNT_W'(FIFO_DEPTH));
    assign baud_done  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign last_char  = (char_idx == IDX_W'(NUM_CHARS - 1));

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when the transmitter is taking a word.
    assign push = data_valid && (!count_full || pop);

    // Next-state and next-output logic. The pop decision uses the live count
    // rather than the registered fifo_empty so that a word pushed into an
    // empty FIFO is taken on the very next edge.
    always_comb begin
        state_next    = state;
        baud_next     = baud_cnt;
        bit_next      = bit_idx;
        char_next     = char_idx;
        word_next     = word_reg;
        cur_char_next = cur_char;
        pop           = 1'b0;

        case (state)
            IDLE: begin
                baud_next = '0;
                if (count != '0) begin
                    pop           = 1'b1;
                    word_next     = mem[rd_ptr];
                    char_next     = '0;
                    cur_char_next = char_of(mem[rd_ptr], '0);
                    state_next    = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (last_char) begin
                        state_next = IDLE;
                    end else begin
                        // Next character of the same word follows with no gap
                        char_next     = char_idx + IDX_W'(1);
                        cur_char_next = char_of(word_reg, char_idx + IDX_W'(1));
                        state_next    = START;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line and busy are registered from the next state so they change on the
    // same edge as the FSM.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = cur_char_next[bit_next];
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            char_idx <= '0;
            word_reg <= '0;
            cur_char <= 8'h00;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            char_idx <= char_next;
            word_reg <= word_next;
            cur_char <= cur_char_next;
            uart_tx  <= tx_next;
            busy     <= busy_next;
        end
    end

    // FIFO pointers, count and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            fifo_empty <= (count == '0);
            fifo_full  <= count_full;
            if (data_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_output_uart_streamer.sv
// tb/tb_output_uart_streamer.sv - scoreboard bench for output_uart_streamer
module tb_output_uart_streamer;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CPB   = 4;
`ifdef OUTPUT_UART_ASCII_HEX_EN
    localparam int NCH = DW / 4 + 2;
`else
    localparam int NCH = DW / 8;
`endif
    localparam int FRAME = NCH * 10 * CPB;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          uart_tx;
    logic          busy;
    logic          fifo_empty;
    logic          fifo_full;
    logic          overflow;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    // Reference model state
    int         pop_edges[$];
    int         last_pop;
    bit         model_ovf;
    logic [7:0] exp_byte[$];
    int         exp_start[$];

    // Monitor state
    bit         mon_active = 1'b0;
    int         mon_k      = 0;
    int         mon_start  = 0;
    logic [7:0] mon_byte   = 8'h00;
    logic       prev_tx    = 1'b1;

    output_uart_streamer #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_valid(data_valid),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .fifo_empty(fifo_empty),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] char_for(input logic [DW-1:0] w, input int c);
        string digits;
        int    nib;
        digits = "0123456789ABCDEF";
`ifdef OUTPUT_UART_ASCII_HEX_EN
        if (c < DW / 4) begin
            nib = int'((w >> (DW - 4 * (c + 1))) & 16'hF);
            return digits[nib];
        end
        return (c == DW / 4) ? 8'h0D : 8'h0A;
`else
        nib = 0;
        if (digits.len() != 16) nib = 1;
        return 8'((w >> (DW - 8 * (c + 1))) + DW'(nib));
`endif
    endfunction

    function automatic void model_reset();
        pop_edges.delete();
        exp_byte.delete();
        exp_start.delete();
        last_pop  = -100000;
        model_ovf = 1'b0;
    endfunction

    // Word pushed at clock edge e: accepted if fewer than DEPTH words are
    // waiting, or if the transmitter takes a word on that same edge. An
    // accepted word is taken at e+1 or one idle cycle after the previous
    // word's frame, whichever is later.
    function automatic void model_push(input logic [DW-1:0] w, input int e);
        int  occ;
        bit  taking;
        int  p;
        occ    = 0;
        taking = 1'b0;
        foreach (pop_edges[i]) begin
            if (pop_edges[i] >= e) occ++;
            if (pop_edges[i] == e) taking = 1'b1;
        end
        if (occ < DEPTH || taking) begin
            p = (e + 1 > last_pop + FRAME + 1) ? e + 1 : last_pop + FRAME + 1;
            last_pop = p;
            pop_edges.push_back(p);
            for (int c = 0; c < NCH; c++) begin
                exp_byte.push_back(char_for(w, c));
                exp_start.push_back(p + c * 10 * CPB);
            end
        end else begin
            model_ovf = 1'b1;
        end
    endfunction

    // Must be called at a falling edge; the word is sampled at the next rising edge.
    task automatic push_word(input logic [DW-1:0] w);
        data_in    = w;
        data_valid = 1'b1;
        model_push(w, cyc + 1);
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_byte.size() != 0 || busy) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_byte.size());
        end
        repeat (4) @(negedge clk);
    endtask

    // UART decoder and scoreboard comparator
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            mon_active = 1'b0;
            prev_tx    = 1'b1;
        end else begin
            if (!mon_active) begin
                if (prev_tx && !uart_tx) begin
                    mon_active = 1'b1;
                    mon_k      = 0;
                    mon_start  = cyc;
                end
            end else begin
                mon_k++;
                if (mon_k == CPB / 2) begin
                    chk("start_bit", int'(uart_tx), 0);
                end else if (mon_k == 9 * CPB + CPB / 2) begin
                    chk("stop_bit", int'(uart_tx), 1);
                    if (exp_byte.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h expected none", mon_byte);
                    end else begin
                        chk("byte", int'(mon_byte), int'(exp_byte.pop_front()));
                        chk("start_edge", mon_start, exp_start.pop_front());
                    end
                    mon_active = 1'b0;
                end else if (mon_k > CPB / 2 && (mon_k - CPB / 2) % CPB == 0) begin
                    mon_byte[(mon_k - CPB / 2) / CPB - 1] = uart_tx;
                end
            end
            prev_tx = uart_tx;
        end
    end

    initial begin
        int n;
        int p2;
        int pf;
        reset      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", int'(uart_tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fifo_empty", int'(fifo_empty), 1);
        chk("rst_fifo_full", int'(fifo_full), 0);
        chk("rst_overflow", int'(overflow), 0);
        #1 reset = 1'b1;
        @(negedge clk);

        // Single word: latency, busy length, empty flag timing
        push_word(16'h1A2F);
        @(negedge clk);
        chk("lat_uart_tx", int'(uart_tx), 0);
        chk("lat_busy", int'(busy), 1);
        chk("lat_fifo_empty_n1", int'(fifo_empty), 0);
        @(negedge clk);
        chk("lat_fifo_empty_n2", int'(fifo_empty), 1);
        n = 2;
        @(negedge clk);
        while (busy === 1'b1 && n < FRAME + 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, FRAME);
        chk("idle_uart_tx", int'(uart_tx), 1);
        drain();

        // Back-to-back words on consecutive cycles
        push_word(16'h0000);
        push_word(16'hFFFF);
        drain();

        // Random words with random gaps, drops allowed
        for (int i = 0; i < 25; i++) begin
            push_word(DW'($urandom));
            repeat ($urandom_range(0, FRAME * 3 / 2)) @(negedge clk);
        end
        drain();
        chk("rand_overflow", int'(overflow), int'(model_ovf));

        // Overflow: ten consecutive pushes from idle
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 10; i++) push_word(DW'(i));
        @(negedge clk);
        chk("ovf_fifo_full", int'(fifo_full), 1);
        chk("ovf_overflow", int'(overflow), 1);
        chk("ovf_model", int'(model_ovf), 1);
        drain();

        // Push on the exact pop cycle while full
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) push_word(DW'($urandom));
        @(negedge clk);
        chk("full_before", int'(fifo_full), 1);
        p2 = pop_edges[1];
        pf = 0;
        while (cyc + 1 < p2 && pf < 5000) begin
            @(negedge clk);
            pf++;
        end
        push_word(16'h00BB);
        @(negedge clk);
        chk("full_after_pop_push", int'(fifo_full), 1);
        chk("no_overflow", int'(overflow), 0);
        chk("no_overflow_model", int'(model_ovf), 0);
        drain();

        // Asynchronous reset in the middle of a data bit
        push_word(16'h1234);
        push_word(16'h5678);
        push_word(16'h9ABC);
        pf = pop_edges[0];
        while (cyc < pf + CPB + 5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_uart_tx", int'(uart_tx), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_fifo_empty", int'(fifo_empty), 1);
        chk("abort_overflow", int'(overflow), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        push_word(16'h0042);
        drain();
        chk("final_empty_queue", exp_byte.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
